// File: rtl/fir_tap_loader_if.sv
// fir_tap_loader_if: tap stream handshake from the loader into the FIR tap port
interface fir_tap_loader_if #(
    parameter int G_TAP_WIDTH = 16
);
    logic [G_TAP_WIDTH-1:0] tap_dout;
    logic                   tap_dout_valid;
    logic                   tap_dout_ready;

    modport master (
        output tap_dout,
        output tap_dout_valid,
        input  tap_dout_ready
    );

    modport slave (
        input  tap_dout,
        input  tap_dout_valid,
        output tap_dout_ready
    );
endinterface

// File: rtl/fir_tap_loader.sv
// fir_tap_loader: local tap table that flushes the FIR, then streams every tap in index order
module fir_tap_loader #(
    parameter int G_NUM_TAPS_LOG2 = 4,
    parameter int G_TAP_WIDTH     = 16,
    parameter int G_FLUSH_CYCLES  = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [G_NUM_TAPS_LOG2-1:0] cfg_wr_addr,
    input  logic [G_TAP_WIDTH-1:0]     cfg_wr_data,
    input  logic                       cfg_wr_valid,
    output logic                       cfg_wr_err,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic                       fir_enable,
    fir_tap_loader_if.master           tap
);
    localparam int T = 1 << G_NUM_TAPS_LOG2;
    localparam logic [G_NUM_TAPS_LOG2-1:0] LAST_IDX = G_NUM_TAPS_LOG2'(T - 1);
    localparam logic [G_NUM_TAPS_LOG2-1:0] ONE_IDX = G_NUM_TAPS_LOG2'(1);
    localparam logic [3:0] FLUSH_INIT = 4'(G_FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, FLUSH, STREAM, DONE} state_t;

    state_t                     state, state_nx;
    logic [G_TAP_WIDTH-1:0]     tap_table [T];
    logic [G_NUM_TAPS_LOG2-1:0] idx, idx_nx;
    logic [3:0]                 cnt, cnt_nx;
    logic                       busy_nx, done_nx, en_nx, valid_nx;
    logic [G_TAP_WIDTH-1:0]     dout_nx;
    logic                       xfer;

    assign xfer = tap.tap_dout_valid && tap.tap_dout_ready;

    // Next-state and next-output decode; every output is registered below
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        idx_nx   = idx;
        busy_nx  = busy;
        done_nx  = done;
        en_nx    = fir_enable;
        valid_nx = tap.tap_dout_valid;
        dout_nx  = tap.tap_dout;
        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nx = FLUSH;
                    busy_nx  = 1'b1;
                    done_nx  = 1'b0;
                    en_nx    = 1'b0;
                    cnt_nx   = FLUSH_INIT;
                end
            end
            FLUSH: begin
                en_nx = 1'b0;
                if (cnt != 4'd0) begin
                    cnt_nx = cnt - 4'd1;
                end else begin
                    state_nx = STREAM;
                    en_nx    = 1'b1;
                    idx_nx   = '0;
                    dout_nx  = tap_table[0];
                    valid_nx = 1'b1;
                end
            end
            STREAM: begin
                if (xfer) begin
                    if (idx != LAST_IDX) begin
                        idx_nx  = idx + ONE_IDX;
                        dout_nx = tap_table[idx + ONE_IDX];
                    end else begin
                        state_nx = DONE;
                        valid_nx = 1'b0;
                        busy_nx  = 1'b0;
                        done_nx  = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // State and registered outputs; reset aborts any load in progress
    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= IDLE;
            cnt                <= '0;
            idx                <= '0;
            busy               <= 1'b0;
            done               <= 1'b0;
            fir_enable         <= 1'b0;
            tap.tap_dout_valid <= 1'b0;
            tap.tap_dout       <= '0;
        end else begin
            state              <= state_nx;
            cnt                <= cnt_nx;
            idx                <= idx_nx;
            busy               <= busy_nx;
            done               <= done_nx;
            fir_enable         <= en_nx;
            tap.tap_dout_valid <= valid_nx;
            tap.tap_dout       <= dout_nx;
        end
    end

    // Tap table: writes land only while idle or done, so a stream never sees a torn table
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < T; i++) tap_table[i] <= '0;
        end else if (cfg_wr_valid && !busy) begin
            tap_table[cfg_wr_addr] <= cfg_wr_data;
        end
    end

    // One-cycle error pulse for a write dropped because a load is in progress
    always_ff @(posedge clk) begin
        cfg_wr_err <= reset ? 1'b0 : (cfg_wr_valid && busy);
    end
endmodule

// File: tb/tb_fir_tap_loader.sv
// tb_fir_tap_loader: directed checks of flush timing, tap streaming, write rejection and reset abort
module tb_fir_tap_loader;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  cfg_wr_addr = '0;
    logic [15:0] cfg_wr_data = '0;
    logic        cfg_wr_valid = 1'b0;
    logic        start = 1'b0;
    logic        cfg_wr_err, busy, done, fir_enable;

    fir_tap_loader_if #(.G_TAP_WIDTH(16)) tif();

    fir_tap_loader #(
        .G_NUM_TAPS_LOG2(4),
        .G_TAP_WIDTH(16),
        .G_FLUSH_CYCLES(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .cfg_wr_addr(cfg_wr_addr),
        .cfg_wr_data(cfg_wr_data),
        .cfg_wr_valid(cfg_wr_valid),
        .cfg_wr_err(cfg_wr_err),
        .start(start),
        .busy(busy),
        .done(done),
        .fir_enable(fir_enable),
        .tap(tif)
    );

    always #5 clk = ~clk;

    int          n_total = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          last_cyc = 0;
    int          en_cnt = 0;
    bit          rand_mode = 1'b0;
    bit          hold = 1'b0;
    logic [15:0] hold_val = '0;
    logic [15:0] model [16];
    logic [15:0] got [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Transfer monitor: records accepted taps and checks tap_dout holds while stalled
    always @(posedge clk) begin
        cyc++;
        if (hold && tif.tap_dout_valid) chk("hold", tif.tap_dout, hold_val);
        hold = tif.tap_dout_valid && !tif.tap_dout_ready;
        hold_val = tif.tap_dout;
        if (tif.tap_dout_valid && tif.tap_dout_ready) begin
            got.push_back(tif.tap_dout);
            last_cyc = cyc;
        end
    end

    // FIR model: ready comes up two cycles after enable, optionally toggling afterwards
    always @(negedge clk) begin
        if (!fir_enable) en_cnt = 0;
        else if (en_cnt < 2) en_cnt++;
        tif.tap_dout_ready = (en_cnt >= 2) && (!rand_mode || $urandom_range(0, 1) == 1);
    end

    task automatic wr(input logic [3:0] a, input logic [15:0] d);
        @(negedge clk);
        cfg_wr_addr = a;
        cfg_wr_data = d;
        cfg_wr_valid = 1'b1;
        @(negedge clk);
        cfg_wr_valid = 1'b0;
        model[a] = d;
    endtask

    task automatic go(input string tag, input bit wr0, input bit err_t, input bit spam);
        int lows;
        int stage;
        bit sp;
        stage = 0;
        sp = 1'b0;
        @(negedge clk);
        start = 1'b1;
        if (wr0) begin
            cfg_wr_addr = 4'd0;
            cfg_wr_data = 16'h8000;
            cfg_wr_valid = 1'b1;
            model[0] = 16'h8000;
        end
        got.delete();
        @(negedge clk);
        start = spam;
        cfg_wr_valid = 1'b0;
        chk({tag, ":busy_start"}, busy, 1);
        chk({tag, ":done_drop"}, done, 0);
        chk({tag, ":en_low"}, fir_enable, 0);
        lows = 1;
        for (int i = 0; i < 20 && !fir_enable; i++) begin
            @(negedge clk);
            start = spam && i == 0;
            if (!fir_enable) lows++;
        end
        chk({tag, ":flush_len"}, lows, 2);
        chk({tag, ":valid_with_en"}, tif.tap_dout_valid, 1);
        for (int i = 0; i < 500 && !done; i++) begin
            @(negedge clk);
            if (spam && !sp && got.size() >= 5) begin
                start = 1'b1;
                sp = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (err_t) begin
                if (stage == 0 && got.size() >= 3) begin
                    cfg_wr_addr = 4'd5;
                    cfg_wr_data = 16'h7fff;
                    cfg_wr_valid = 1'b1;
                    stage = 1;
                end else if (stage == 1) begin
                    cfg_wr_valid = 1'b0;
                    chk({tag, ":err_pulse"}, cfg_wr_err, 1);
                    stage = 2;
                end else if (stage == 2) begin
                    chk({tag, ":err_clear"}, cfg_wr_err, 0);
                    stage = 3;
                end
            end
        end
        start = 1'b0;
        chk({tag, ":done"}, done, 1);
        chk({tag, ":done_lat"}, cyc, last_cyc);
        chk({tag, ":busy_end"}, busy, 0);
        chk({tag, ":en_end"}, fir_enable, 1);
        chk({tag, ":count"}, got.size(), 16);
        for (int k = 0; k < 16; k++)
            chk($sformatf("%s:tap%0d", tag, k), k < got.size() ? 32'(got[k]) : 32'hdead_beef, model[k]);
        if (err_t) chk({tag, ":err_seen"}, stage, 3);
        if (spam) begin
            repeat (4) @(negedge clk);
            chk({tag, ":no_restart_done"}, done, 1);
            chk({tag, ":no_restart_busy"}, busy, 0);
            chk({tag, ":no_restart_count"}, got.size(), 16);
        end
    endtask

    initial begin
        for (int k = 0; k < 16; k++) model[k] = '0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst:busy", busy, 0);
        chk("rst:done", done, 0);
        chk("rst:en", fir_enable, 0);
        chk("rst:valid", tif.tap_dout_valid, 0);
        chk("rst:dout", tif.tap_dout, 0);
        chk("rst:err", cfg_wr_err, 0);
        for (int k = 0; k < 16; k++) wr(4'(k), 16'(3 * k));
        go("base", 1'b0, 1'b0, 1'b0);
        rand_mode = 1'b1;
        go("rand", 1'b0, 1'b1, 1'b0);
        rand_mode = 1'b0;
        go("wrstart", 1'b1, 1'b0, 1'b0);
        go("spam", 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        start = 1'b1;
        got.delete();
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 200 && got.size() < 7; i++) @(negedge clk);
        chk("abort:seven", got.size(), 7);
        reset = 1'b1;
        @(negedge clk);
        chk("abort:en", fir_enable, 0);
        chk("abort:valid", tif.tap_dout_valid, 0);
        chk("abort:busy", busy, 0);
        chk("abort:done", done, 0);
        reset = 1'b0;
        for (int k = 0; k < 16; k++) model[k] = '0;
        go("zeros", 1'b0, 1'b0, 1'b0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/fir_tap_loader.md
Name: fir_tap_loader

Overview:
Upstream companion to the configurable FIR. It holds a local tap table written through a simple config write port. On a start command it drops the FIR's enable for a fixed flush period so the FIR re-enters its init state, then streams the full tap table in index order over the FIR's tap valid/ready handshake. It owns the FIR enable line and reports busy/done status to the control plane.

Parameters:
G_NUM_TAPS_LOG2, 4, log2 of total tap count T; must equal FIR G_NUM_STAGES_LOG2 + G_STAGE_DEPTH_LOG2.
G_TAP_WIDTH, 16, tap word width; must equal FIR G_TAP_WIDTH.
G_FLUSH_CYCLES, 2, number of cycles fir_enable is held low before streaming; legal range 1..15.

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
cfg_wr_addr  in  G_NUM_TAPS_LOG2  tap table write index
cfg_wr_data  in  G_TAP_WIDTH  tap value, signed two's complement, passed through unchanged
cfg_wr_valid  in  1  write strobe; single-cycle, no ready
cfg_wr_err  out  1  one-cycle pulse when a write is rejected
start  in  1  single-cycle load command
busy  out  1  high during FLUSH and STREAM
done  out  1  level; high from load completion until the next accepted start
fir_enable  out  1  drives FIR enable
tap_dout  out  G_TAP_WIDTH  tap value to FIR tap_din
tap_dout_valid  out  1  to FIR tap_din_valid
tap_dout_ready  in  1  from FIR tap_din_ready

Behaviour:
- Reset values:
  - state IDLE.
  - fir_enable, tap_dout_valid, busy, done, cfg_wr_err all 0; tap_dout = 0.
  - Tap index = 0; flush counter = 0.
  - All T tap table entries cleared to 0.
- Reset mid-operation aborts immediately with the same values. fir_enable=0 returns the FIR to its init state.
- Tap table: T registers.
  - A write is accepted when cfg_wr_valid=1 and busy=0; the entry updates at the next edge.
  - When busy=1, the write is dropped and cfg_wr_err=1 on the following cycle only.
- State machine: IDLE, FLUSH, STREAM, DONE. All outputs are registered.
- IDLE: fir_enable=0. On start: busy<=1, done<=0, fir_enable<=0, counter<=G_FLUSH_CYCLES-1, go to FLUSH.
- FLUSH: fir_enable=0.
  - While counter != 0, decrement.
  - When counter == 0: fir_enable<=1, idx<=0, tap_dout<=table[0], tap_dout_valid<=1, go to STREAM.
- STREAM: fir_enable=1. A transfer occurs on tap_dout_valid & tap_dout_ready.
  - Transfer with idx < T-1: idx<=idx+1, tap_dout<=table[idx+1], tap_dout_valid stays 1.
  - Transfer with idx == T-1: tap_dout_valid<=0, busy<=0, done<=1, go to DONE.
  - tap_dout is stable while valid=1 and ready=0. Valid is never withdrawn before its transfer.
- DONE: fir_enable held 1 so the FIR keeps filtering; done held 1.
  - On start: same actions as start in IDLE. fir_enable drops the next cycle and the FIR re-initialises.
- start during FLUSH or STREAM is ignored. No error is flagged.
- A write and a start in the same cycle from IDLE/DONE: the write is accepted, and the new value is streamed because table reads happen no earlier than the FLUSH exit.
- Latency:
  - start sampled at edge 0; fir_enable=0 for G_FLUSH_CYCLES cycles after edge 0.
  - First tap_dout_valid=1 coincides with fir_enable=1, G_FLUSH_CYCLES+1 edges after start.
  - The FIR raises its ready 2 cycles after enable; the handshake absorbs this gap.
- With ready held high, the full load of T taps takes T cycles after the first ready.
- done asserts 1 cycle after the last transfer.

Test Plan:
- Reset, write table[k]=3k for k=0..15, start; FIR model ready after 2 cycles then held 1 -> tap_dout sequence 0,3,...,45, one per cycle; done=1 one cycle after the 45 transfer; busy=0; fir_enable stays 1.
- Same load with ready toggling pseudo-randomly -> exactly 16 transfers, in order, no duplicates or skips; tap_dout constant while ready=0.
- Write addr 5 = 0x7FFF during STREAM -> cfg_wr_err pulses 1 cycle; next load streams the old table[5]=15 at position 5.
- From DONE, write table[0]=0x8000 and start in the same cycle -> fir_enable low exactly 2 cycles; first streamed tap is 0x8000; done drops the cycle after start.
- Assert reset after the 7th transfer -> next cycle: fir_enable=0, tap_dout_valid=0, busy=0; a new start streams all zeros.
- Pulse start twice during FLUSH and once during STREAM -> single load of 16 taps, no restart.
